rx_sync_sequencer: RTL
======================

// Module: rx_sync_sequencer
// PURPOSE
//  Frame-acquisition controller for the RX chain. Sits between the correlator SOP output and
//  fr_sync/rmcp: qualifies raw preamble detections against a flywheel frame counter, runs the
//  SEARCH/VERIFY/LOCK/DROP sequence, emits a regenerated frame SOP and acceptance window, and
//  pulses a datapath reset on loss of lock. Also relaxes the correlator threshold while searching.
// PARAMETERS
//  pSYM_LEN   1056   samples per OFDM symbol (1024 + 32 CP)
//  pSB_NUM    50     symbols per frame; frame length F = pSYM_LEN*pSB_NUM = 52800
//  pWIN       4      half-width of the SOP acceptance window, in samples
//  pN_LOCK    5      consecutive in-window hits needed to declare lock
//  pN_UNLOCK  10     consecutive missed windows in LOCK before dropping
//  pRST_LEN   16     length of odp_rst pulse, cycles
//  pTHR_W     24     threshold width
// PORTS
//  clk        in   1       sample clock (clk_low_data domain)
//  rst        in   1       synchronous, active-high reset
//  isop       in   1       raw correlator peak pulse
//  ithr_lvl   in   pTHR_W  nominal correlator threshold
//  ithr_min   in   pTHR_W  floor for relaxed threshold
//  ithr_step  in   pTHR_W  decrement per empty search frame
//  osop       out  1       regenerated frame SOP, one-cycle pulse, LOCK only
//  owin       out  1       high while effective phase is inside the acceptance window
//  ofound     out  1       high in LOCK
//  odp_rst    out  1       active-high reset for downstream datapath
//  othr_lvl   out  pTHR_W  threshold to correlator
//  ostate     out  2       0 SEARCH, 1 VERIFY, 2 LOCK, 3 DROP
//  omiss      out  4       current consecutive-miss count
// BEHAVIOUR
//  Reset: state SEARCH, phase 0, hit 0, miss 0; osop/owin/ofound/odp_rst 0; othr_lvl = ithr_lvl.
//  Phase: counts 0..F-1, wraps F-1 -> 0. Window = phase in [F-pWIN, F-1] or [0, pWIN].
//  Accepted isop: the isop cycle counts as effective phase 0 and next phase = 1 (re-centering).
//   Only the first isop per window is accepted; later ones in the same window are ignored.
//  SEARCH: phase free-runs. Any isop -> VERIFY, hit = 1, phase realigned.
//   Each full frame without isop: othr_lvl = max(othr_lvl - ithr_step, ithr_min), with no underflow
//   (if othr_lvl < ithr_step + ithr_min, the result is ithr_min).
//  VERIFY: accepted isop -> hit+1; hit reaching pN_LOCK -> LOCK, miss = 0, othr_lvl = ithr_lvl.
//   Window closes (phase == pWIN) with no accepted isop -> SEARCH, hit = 0. An isop on the
//   closing cycle counts as a hit.
//  LOCK: at each window close, a hit sets miss = 0; otherwise miss+1. miss reaching
//   pN_UNLOCK -> DROP. osop = registered(state==LOCK && effective phase==0), i.e. 1-cycle
//   latency, emitted on missed windows too (flywheel).
//  DROP: odp_rst high for exactly pRST_LEN cycles, starting the cycle after entry; isop ignored;
//   then SEARCH, phase 0, hit 0, miss 0, othr_lvl = ithr_lvl. isop on the DROP->SEARCH cycle
//   is ignored.
//  owin: registered, 1-cycle latency vs phase; forced 0 in SEARCH and DROP.
//  ithr_lvl changes while in VERIFY/LOCK propagate next cycle; in SEARCH only on relax/reload.
//  rst at any time overrides everything, including mid-DROP, and terminates odp_rst immediately.
//  Counter widths: phase ceil(log2(F)) = 16 bit; hit/miss saturate and never wrap.
// STRUCTURE
//  rx_sync_pkg: state enum (SEARCH, VERIFY, LOCK, DROP), F, window bounds, width functions.
//  Sub-module rx_frame_phase: phase counter with realign input and window/close/zero flags.
//   FSM, hit/miss counters and threshold logic stay in the top.
// TESTING
//  1 isop every 52800 cycles x6 -> VERIFY after #1, LOCK on #5, osop 1 cycle after each isop.
//  2 In LOCK, stop isop -> ofound falls after 10th missed window close; odp_rst high 16 cycles; then SEARCH.
//  3 In LOCK, isop at +3 then +4 offsets -> accepted and re-centered; isop at +5 -> counted as a miss, ignored.
//  4 VERIFY, one frame without isop -> SEARCH at phase==pWIN, hit=0, no osop ever.
//  5 SEARCH, thr=1000, step=300, min=200, no isop -> 700, 400, 200, 200 at successive frame ends.
//  6 rst asserted on cycle 5 of DROP -> odp_rst 0 next cycle, ostate 0, othr_lvl = ithr_lvl.

Source files
------------

// File: rtl/rx_sync_pkg.sv
// Shared constants, state encodings and width helpers for the RX
// frame-acquisition sequencer.
package rx_sync_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_SEARCH = 2'd0;
    localparam state_t ST_VERIFY = 2'd1;
    localparam state_t ST_LOCK   = 2'd2;
    localparam state_t ST_DROP   = 2'd3;

    localparam int SYM_LEN_DEF  = 1056;
    localparam int SB_NUM_DEF   = 50;
    localparam int WIN_DEF      = 4;
    localparam int N_LOCK_DEF   = 5;
    localparam int N_UNLOCK_DEF = 10;
    localparam int RST_LEN_DEF  = 16;
    localparam int THR_W_DEF    = 24;

    function automatic int frame_len(input int sym_len, input int sb_num);
        return sym_len * sb_num;
    endfunction

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_w(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int win_lo(input int frame, input int half_win);
        return frame - half_win;
    endfunction

    function automatic int win_hi(input int half_win);
        return half_win;
    endfunction

endpackage

// File: rtl/rx_frame_phase.sv
// Flywheel frame-phase counter with realign/clear controls and
// acceptance-window flags derived from the raw and effective phase.
module rx_frame_phase
    import rx_sync_pkg::*;
#(
    parameter  int pFRAME = frame_len(SYM_LEN_DEF, SB_NUM_DEF),
    parameter  int pWIN   = WIN_DEF,
    localparam int PW     = cnt_w(pFRAME - 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic realign,
    input  logic clear,
    output logic raw_win,
    output logic eff_zero,
    output logic eff_win,
    output logic close,
    output logic frame_end
);

    localparam logic [PW-1:0] LAST = PW'(pFRAME - 1);
    localparam logic [PW-1:0] WLO  = PW'(win_lo(pFRAME, pWIN));
    localparam logic [PW-1:0] WHI  = PW'(win_hi(pWIN));

    logic [PW-1:0] phase;
    logic [PW-1:0] eff;

    // A realigning pulse makes the current cycle phase zero.
    assign eff       = realign ? '0 : phase;

    assign raw_win   = (phase <= WHI) || (phase >= WLO);
    assign eff_win   = (eff <= WHI) || (eff >= WLO);
    assign eff_zero  = (eff == '0);
    assign close     = (eff == WHI);
    assign frame_end = (phase == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase <= '0;
        end else if (realign) begin
            phase <= PW'(1);
        end else if (phase == LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

endmodule

// File: rtl/rx_sync_sequencer.sv
// Frame acquisition: SEARCH/VERIFY/LOCK/DROP sequencing, SOP regeneration,
// datapath reset on lock loss and correlator threshold relaxation.
module rx_sync_sequencer
    import rx_sync_pkg::*;
#(
    parameter int pSYM_LEN  = SYM_LEN_DEF,
    parameter int pSB_NUM   = SB_NUM_DEF,
    parameter int pWIN      = WIN_DEF,
    parameter int pN_LOCK   = N_LOCK_DEF,
    parameter int pN_UNLOCK = N_UNLOCK_DEF,
    parameter int pRST_LEN  = RST_LEN_DEF,
    parameter int pTHR_W    = THR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isop,
    input  logic [pTHR_W-1:0] ithr_lvl,
    input  logic [pTHR_W-1:0] ithr_min,
    input  logic [pTHR_W-1:0] ithr_step,
    output logic              osop,
    output logic              owin,
    output logic              ofound,
    output logic              odp_rst,
    output logic [pTHR_W-1:0] othr_lvl,
    output logic [1:0]        ostate,
    output logic [3:0]        omiss
);

    localparam int F  = frame_len(pSYM_LEN, pSB_NUM);
    localparam int HW = cnt_w(pN_LOCK);
    localparam int DW = cnt_w(pRST_LEN);

    localparam logic [HW-1:0] HIT_LOCK  = HW'(pN_LOCK);
    localparam logic [3:0]    MISS_DROP = 4'(pN_UNLOCK);
    localparam logic [DW-1:0] DROP_END  = DW'(pRST_LEN);

    state_t            state;
    logic [HW-1:0]     hit;
    logic [HW-1:0]     hit_inc;
    logic [3:0]        miss;
    logic [3:0]        miss_inc;
    logic              win_hit;
    logic [DW-1:0]     drop_cnt;
    logic [pTHR_W-1:0] thr;
    logic [pTHR_W:0]   floor_sum;
    logic [pTHR_W-1:0] relaxed;

    logic tracking;
    logic accept;
    logic clear;
    logic raw_win;
    logic eff_zero;
    logic eff_win;
    logic close;
    logic frame_end;

    assign tracking = (state == ST_VERIFY) || (state == ST_LOCK);

    // Only the first in-window pulse per window re-centres the flywheel.
    assign accept = isop &&
                    ((state == ST_SEARCH) ||
                     (tracking && raw_win && !win_hit));

    assign clear = (state == ST_DROP) && (drop_cnt == DROP_END);

    assign hit_inc  = (hit == HIT_LOCK) ? hit : hit + HW'(1);
    assign miss_inc = (miss == 4'hF) ? miss : miss + 4'd1;

    // Relax without underflow: never go below the floor.
    assign floor_sum = {1'b0, ithr_min} + {1'b0, ithr_step};
    assign relaxed   = ({1'b0, thr} < floor_sum) ? ithr_min
                                                 : thr - ithr_step;

    rx_frame_phase #(
        .pFRAME (F),
        .pWIN   (pWIN)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .realign   (accept),
        .clear     (clear),
        .raw_win   (raw_win),
        .eff_zero  (eff_zero),
        .eff_win   (eff_win),
        .close     (close),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_SEARCH;
            hit      <= '0;
            miss     <= '0;
            win_hit  <= 1'b0;
            drop_cnt <= '0;
            thr      <= ithr_lvl;
            osop     <= 1'b0;
            owin     <= 1'b0;
            odp_rst  <= 1'b0;
        end else begin
            osop    <= (state == ST_LOCK) && eff_zero;
            owin    <= tracking && eff_win;
            odp_rst <= 1'b0;

            unique case (1'b1)
                (state == ST_SEARCH): begin
                    if (accept) begin
                        state   <= ST_VERIFY;
                        hit     <= HW'(1);
                        win_hit <= 1'b1;
                    end else if (frame_end) begin
                        thr <= relaxed;
                    end
                end

                (state == ST_VERIFY): begin
                    thr <= ithr_lvl;
                    if (accept) begin
                        win_hit <= 1'b1;
                        hit     <= hit_inc;
                        if (hit_inc == HIT_LOCK) begin
                            state <= ST_LOCK;
                            miss  <= '0;
                        end
                    end else if (close) begin
                        win_hit <= 1'b0;
                        if (!win_hit) begin
                            state <= ST_SEARCH;
                            hit   <= '0;
                        end
                    end
                end

                (state == ST_LOCK): begin
                    thr <= ithr_lvl;
                    if (accept) begin
                        win_hit <= 1'b1;
                    end else if (close) begin
                        win_hit <= 1'b0;
                        if (win_hit) begin
                            miss <= '0;
                        end else begin
                            miss <= miss_inc;
                            if (miss_inc == MISS_DROP) begin
                                state    <= ST_DROP;
                                drop_cnt <= '0;
                            end
                        end
                    end
                end

                (state == ST_DROP): begin
                    if (drop_cnt == DROP_END) begin
                        state    <= ST_SEARCH;
                        hit      <= '0;
                        miss     <= '0;
                        win_hit  <= 1'b0;
                        drop_cnt <= '0;
                        thr      <= ithr_lvl;
                    end else begin
                        odp_rst  <= 1'b1;
                        drop_cnt <= drop_cnt + DW'(1);
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign ofound   = (state == ST_LOCK);
    assign othr_lvl = thr;
    assign ostate   = state;
    assign omiss    = miss;

endmodule
